// File: rtl/lane_word_aligner.sv
// Per-lane word aligner: a bit-slip window over {data_in, prev} followed by polarity correction.
// Optional macro LANE_ALIGNER_SLIP_COUNT_EN enables the saturating dbg_slip_count counter.
module lane_word_aligner #(
   parameter int DWIDTH              = 32,
   parameter int HOLDOFF             = 4,
   parameter int BITSLIP_SHIFT_RIGHT = 1
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic [DWIDTH-1:0] data_in,
   input  logic              data_in_valid,
   input  logic              bit_slip,
   input  logic              lane_polarity,
   output logic [DWIDTH-1:0] data_out,
   output logic              data_out_valid,
   output logic              slip_busy,
   output logic [7:0]        dbg_slip_count
);

   localparam int OW = $clog2(DWIDTH);
   localparam logic [OW-1:0] OFF_MAX   = OW'(DWIDTH - 1);
   localparam logic [OW-1:0] OFF_ONE   = OW'(1);
   localparam logic [7:0]    HOLD_LOAD = 8'(HOLDOFF);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [OW-1:0]       off_q, off_d;
   logic [7:0]          hold_q, hold_d;
   logic [DWIDTH-1:0]   prev_q;
   logic [2*DWIDTH-1:0] window;
   logic [DWIDTH-1:0]   sel;

   assign window    = {data_in, prev_q};
   assign sel       = window[off_q +: DWIDTH];
   assign slip_busy = (state_q == HOLD);

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (bit_slip) begin
               state_d = HOLD;
               hold_d  = HOLD_LOAD;
               if (BITSLIP_SHIFT_RIGHT != 0)
                  off_d = (off_q == OFF_MAX) ? '0 : off_q + OFF_ONE;
               else
                  off_d = (off_q == '0) ? OFF_MAX : off_q - OFF_ONE;
            end
         end
         HOLD: begin
            hold_d = hold_q - 8'd1;
            // Leave on the edge where the counter hits zero.
            if (hold_q <= 8'd1)
               state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= IDLE;
         off_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         hold_q  <= hold_d;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         prev_q         <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= data_in_valid;
         if (data_in_valid) begin
            prev_q   <= data_in;
            data_out <= sel ^ {DWIDTH{lane_polarity}};
         end
      end
   end

`ifdef LANE_ALIGNER_SLIP_COUNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)
         cnt_q <= '0;
      else if ((state_q == IDLE) && bit_slip && (cnt_q != 8'hFF))
         cnt_q <= cnt_q + 8'd1;
   end

   assign dbg_slip_count = cnt_q;
`else
   assign dbg_slip_count = '0;
`endif

endmodule
